seg_display_decoder: RTL and testbench
======================================

SEG_DISPLAY_DECODER -- requirements
Module: seg_display_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 1..15: the number of consecutive edges a pattern must repeat before it is decoded.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have seg_tens, input, 7 bits: tens-digit segments; bit0=a through bit6=g; 1 = segment lit.
REQ-005 SHALL have seg_ones, input, 7 bits: ones-digit segments, same encoding as seg_tens.
REQ-006 SHALL have out_rdy, input, 1 bit: consumer ready.
REQ-007 SHALL have out_val, output, 1 bit: decoded result valid.
REQ-008 SHALL have out, output, 5 bits: decoded binary value (0..31).
REQ-009 SHALL have err, output, 1 bit: the presented pattern is invalid; qualified by out_val.

Function
REQ-010 SHALL decode each digit only from these exact patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; any other non-zero pattern is invalid.
REQ-011 SHALL compute out = tens*10 + ones when both digits are valid, tens <= 3, and the sum <= 31; otherwise it SHALL present err=1 with out=5'd0.
REQ-012 SHALL treat seg_tens=0x00 together with seg_ones=0x00 as blank: never presented, no err.
REQ-013 SHALL register {seg_tens,seg_ones} into samp on every edge, in every state.
REQ-014 SHALL clear the 4-bit counter cnt to 0 on each edge where the input differs from samp; otherwise cnt increments, saturating at STABLE_CYCLES-1.
REQ-015 SHALL define the pattern as stable on an edge where the input equals samp and cnt == STABLE_CYCLES-1.
REQ-016 SHALL have two states: FILTER and PRESENT.
REQ-017 SHALL, in FILTER, on a stable edge with a non-blank pattern that differs from last_pat (or with last_pat_vld=0), load out/err, store last_pat, set last_pat_vld, and go to PRESENT.
REQ-018 SHALL, with that timing, raise out_val after the (STABLE_CYCLES+1)th consecutive edge on which the new pattern is present.
REQ-019 SHALL, on a stable blank pattern in FILTER, clear last_pat_vld, so the same value is re-presented after a blank.
REQ-020 SHALL, in PRESENT, hold out_val=1 with out/err unchanged until the edge where out_val & out_rdy, then return to FILTER; out_val falls after that edge.
REQ-021 SHALL allow the handshake to complete on the first PRESENT edge if out_rdy is already high, so out_val can be a one-cycle pulse.
REQ-022 SHALL continue the samp/cnt tracking during PRESENT; input changes during PRESENT SHALL NOT alter out/err.
REQ-023 SHALL, after returning to FILTER with an already-stable new pattern, present it on the next edge.
REQ-024 SHALL present each distinct stable pattern exactly once; holding a pattern indefinitely SHALL NOT re-assert out_val.
REQ-025 SHALL keep out_val, out and err driven only from registers, with no combinational path from the inputs.

Reset
REQ-026 SHALL, while rst=1, immediately and asynchronously force state=FILTER, out_val=0, out=0, err=0, samp=0, cnt=0, last_pat_vld=0.
REQ-027 SHALL abort any PRESENT transaction on reset, mid-operation, without completing it.
REQ-028 SHALL resume filtering from the first rising edge after rst deasserts.

Verification
REQ-029 SHALL cover: STABLE_CYCLES=4, out_rdy=1, hold 0x06/0x07 -> out_val high only after the 5th edge for exactly 1 cycle, out=17, err=0.
REQ-030 SHALL cover: 0x4F/0x06 stable, then 0x4F/0x5B stable -> out=31, err=0, followed by a separate transaction with err=1, out=0.
REQ-031 SHALL cover: 0x5B/0x3F for 3 edges, then 0x06/0x3F -> no out_val for 20 (the first pattern never reaches STABLE_CYCLES+1 edges), then out=10.
REQ-032 SHALL cover: out_rdy=0 with 0x06/0x6D presented (15), then inputs switched to 0x06/0x7D -> out stays 15 until out_rdy=1, then out=16 follows on the next edge.
REQ-033 SHALL cover: 0x3F/0x66 held 100 cycles -> exactly one transaction (4); then blank, then 0x3F/0x66 again -> a second transaction with out=4.
REQ-034 SHALL cover: rst pulsed while in PRESENT with out_rdy=0 -> out_val=0, out=0 before the next edge; after release, an unchanged stable input is re-presented.

Source files
------------

// File: rtl/seg_display_decoder.sv
// seg_display_decoder
//   Watches a two-digit seven-segment display and converts a settled reading
//   into binary. A reading is accepted only after it has been seen on
//   STABLE_CYCLES+1 consecutive clock edges. Each distinct settled reading is
//   offered exactly once through a valid/ready handshake.
//
// Ports
//   clk       clock; all state updates on the rising edge
//   rst       asynchronous, active-high reset
//   seg_tens  tens-digit segments, bit0=a .. bit6=g, 1 = lit
//   seg_ones  ones-digit segments, same encoding
//   out_rdy   consumer ready
//   out_val   decoded result valid (registered)
//   out       decoded value 0..31 (registered)
//   err       reading is not a legal value 0..31 (registered, qualified by out_val)
module seg_display_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_tens,
    input  logic [6:0] seg_ones,
    input  logic       out_rdy,
    output logic       out_val,
    output logic [4:0] out,
    output logic       err
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

    typedef enum logic {
        FILTER  = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Returns {valid, digit}; only the exact digit glyphs are accepted.
    function automatic logic [4:0] seg_to_digit(input logic [6:0] seg);
        case (seg)
            7'h3F:   seg_to_digit = {1'b1, 4'd0};
            7'h06:   seg_to_digit = {1'b1, 4'd1};
            7'h5B:   seg_to_digit = {1'b1, 4'd2};
            7'h4F:   seg_to_digit = {1'b1, 4'd3};
            7'h66:   seg_to_digit = {1'b1, 4'd4};
            7'h6D:   seg_to_digit = {1'b1, 4'd5};
            7'h7D:   seg_to_digit = {1'b1, 4'd6};
            7'h07:   seg_to_digit = {1'b1, 4'd7};
            7'h7F:   seg_to_digit = {1'b1, 4'd8};
            7'h6F:   seg_to_digit = {1'b1, 4'd9};
            default: seg_to_digit = 5'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [13:0] samp_q, samp_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] last_pat_q, last_pat_d;
    logic        last_pat_vld_q, last_pat_vld_d;
    logic [4:0]  out_q, out_d;
    logic        err_q, err_d;

    logic [13:0] pat_in;
    logic [4:0]  tens_dec, ones_dec;
    logic [6:0]  sum;
    logic        dec_ok;
    logic        same;
    logic        stable;
    logic        blank;

    assign pat_in   = {seg_tens, seg_ones};
    assign tens_dec = seg_to_digit(seg_tens);
    assign ones_dec = seg_to_digit(seg_ones);
    assign sum      = 7'(tens_dec[3:0]) * 7'd10 + 7'(ones_dec[3:0]);
    assign dec_ok   = tens_dec[4] && ones_dec[4] && (tens_dec[3:0] <= 4'd3) && (sum <= 7'd31);

    assign same   = (pat_in == samp_q);
    assign stable = same && (cnt_q == CNT_MAX);
    assign blank  = (pat_in == 14'd0);

    // Sampler and run counter keep tracking in every state.
    always_comb begin
        samp_d = pat_in;
        if (!same) begin
            cnt_d = 4'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_pat_d     = last_pat_q;
        last_pat_vld_d = last_pat_vld_q;
        out_d          = out_q;
        err_d          = err_q;
        case (state_q)
            FILTER: begin
                if (stable) begin
                    if (blank) begin
                        // A settled blank re-arms presentation of the same value.
                        last_pat_vld_d = 1'b0;
                    end else if (!last_pat_vld_q || (pat_in != last_pat_q)) begin
                        out_d          = dec_ok ? sum[4:0] : 5'd0;
                        err_d          = !dec_ok;
                        last_pat_d     = pat_in;
                        last_pat_vld_d = 1'b1;
                        state_d        = PRESENT;
                    end
                end
            end
            PRESENT: begin
                // out/err frozen until the consumer takes them.
                if (out_rdy) begin
                    state_d = FILTER;
                end
            end
            default: state_d = FILTER;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FILTER;
            samp_q         <= 14'd0;
            cnt_q          <= 4'd0;
            last_pat_q     <= 14'd0;
            last_pat_vld_q <= 1'b0;
            out_q          <= 5'd0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            samp_q         <= samp_d;
            cnt_q          <= cnt_d;
            last_pat_q     <= last_pat_d;
            last_pat_vld_q <= last_pat_vld_d;
            out_q          <= out_d;
            err_q          <= err_d;
        end
    end

    assign out_val = (state_q == PRESENT);
    assign out     = out_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Testbench for seg_display_decoder: directed scenarios plus randomized
// display readings, checked by a run-length reference model feeding a
// scoreboard queue that a separate monitor drains on each handshake.
module tb_seg_display_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_tens = 7'd0;
    logic [6:0] seg_ones = 7'd0;
    logic       out_rdy = 1'b0;
    logic       out_val;
    logic [4:0] out;
    logic       err;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    seg_display_decoder #(.STABLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_tens (seg_tens),
        .seg_ones (seg_ones),
        .out_rdy  (out_rdy),
        .out_val  (out_val),
        .out      (out),
        .err      (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int digit_of(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (glyph[i] == s) return i;
        return -1;
    endfunction

    // {err, value} that a reading should produce
    function automatic logic [5:0] expect_of(input logic [6:0] t, input logic [6:0] o);
        int dt, d1, v;
        dt = digit_of(t);
        d1 = digit_of(o);
        if (dt < 0 || d1 < 0 || dt > 3) return {1'b1, 5'd0};
        v = dt * 10 + d1;
        if (v > 31) return {1'b1, 5'd0};
        return {1'b0, 5'(v)};
    endfunction

    logic [5:0]  sb_q[$];
    logic [13:0] m_prev = 14'd0;
    int          m_run = 1;       // edges on which m_prev has been present
    bit          m_busy = 0;
    logic [13:0] m_last = 14'd0;
    bit          m_lastvld = 0;

    always @(posedge clk or posedge rst) begin
        logic [13:0] p;
        if (rst) begin
            m_prev = 14'd0; m_run = 1; m_busy = 0; m_lastvld = 0;
            sb_q.delete();
        end else begin
            p = {seg_tens, seg_ones};
            if (p == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else begin m_prev = p; m_run = 1; end
            if (m_busy) begin
                if (out_rdy) m_busy = 0;
            end else if (m_run >= S + 1) begin
                if (p == 14'd0) m_lastvld = 0;
                else if (!m_lastvld || p != m_last) begin
                    sb_q.push_back(expect_of(seg_tens, seg_ones));
                    m_last = p; m_lastvld = 1; m_busy = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        checks++;
        if (out_val !== m_busy) begin
            errors++;
            $display("FAIL out_val timing: got %b expected %b at %0t", out_val, m_busy, $time);
        end
        if (out_val === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected result: got out=%0d err=%b with empty scoreboard", out, err);
            end else if ({err, out} !== sb_q[0]) begin
                errors++;
                $display("FAIL result: got out=%0d err=%b expected out=%0d err=%b",
                         out, err, sb_q[0][4:0], sb_q[0][5]);
            end
            if (out_rdy) begin
                hs_cnt++;
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] t, input logic [6:0] o, input logic r, input int n);
        seg_tens = t; seg_ones = o; out_rdy = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [6:0] bad_pool [4] = '{7'h01, 7'h7E, 7'h40, 7'h77};

    initial begin
        int hs0;
        logic [6:0] t, o;
        #12;
        check("reset out_val", out_val, 0);
        check("reset out", out, 0);
        check("reset err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(7'h00, 7'h00, 1, 10);
        check("blank never presented", hs_cnt, 0);

        // single value 17 with consumer always ready
        drive(7'h06, 7'h07, 1, S);
        check("17 not before 5th edge", out_val, 0);
        drive(7'h06, 7'h07, 1, 1);
        check("17 valid after 5th edge", out_val, 1);
        check("17 value", out, 17);
        check("17 err", err, 0);
        drive(7'h06, 7'h07, 1, 1);
        check("17 one-cycle pulse", out_val, 0);

        // 31 then an overflowing 32
        drive(7'h4F, 7'h06, 1, 8);
        drive(7'h4F, 7'h5B, 1, 8);

        // short glitch on 20 must not be presented
        hs0 = hs_cnt;
        drive(7'h5B, 7'h3F, 1, 3);
        drive(7'h06, 7'h3F, 1, 8);
        check("glitch suppressed count", hs_cnt - hs0, 1);

        // back-pressure: 15 held while input moves to 16
        drive(7'h06, 7'h6D, 0, 10);
        drive(7'h06, 7'h7D, 0, 10);
        check("15 held valid", out_val, 1);
        check("15 held value", out, 15);
        drive(7'h06, 7'h7D, 1, 1);
        check("15 released", out_val, 0);
        drive(7'h06, 7'h7D, 1, 1);
        check("16 next edge valid", out_val, 1);
        check("16 value", out, 16);
        drive(7'h06, 7'h7D, 1, 2);

        // long hold presents once; blank re-arms
        hs0 = hs_cnt;
        drive(7'h3F, 7'h66, 1, 100);
        check("long hold one transaction", hs_cnt - hs0, 1);
        drive(7'h00, 7'h00, 1, 8);
        drive(7'h3F, 7'h66, 1, 10);
        check("re-presented after blank", hs_cnt - hs0, 2);

        // reset while presenting
        drive(7'h06, 7'h3F, 0, 10);
        check("pre-reset valid", out_val, 1);
        #2 rst = 1'b1;
        #1;
        check("async reset out_val", out_val, 0);
        check("async reset out", out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(7'h06, 7'h3F, 0, S);
        check("post-reset not yet valid", out_val, 0);
        drive(7'h06, 7'h3F, 0, 1);
        check("post-reset re-presented", out_val, 1);
        check("post-reset value", out, 10);
        drive(7'h06, 7'h3F, 1, 2);

        // randomized readings
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0: begin t = 7'h00; o = 7'h00; end
                1: begin t = bad_pool[$urandom_range(0, 3)]; o = glyph[$urandom_range(0, 9)]; end
                2: begin t = glyph[$urandom_range(4, 9)]; o = glyph[$urandom_range(0, 9)]; end
                default: begin t = glyph[$urandom_range(0, 3)]; o = glyph[$urandom_range(0, 9)]; end
            endcase
            drive(t, o, 1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        drive(7'h00, 7'h00, 1, 20);
        check("scoreboard drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
